// File: rtl/iecdrv_gcr_reader_if.sv
// iecdrv_gcr_reader_if: RAM bit port plus byte-side outputs of the GCR read head.
// master = reader (mem_addr, byte_out, byte_ready, sync_n out; mem_q in); slave = RAM/VIA side.
interface iecdrv_gcr_reader_if #(
  parameter int ADDRWIDTH = 13
);
  logic [ADDRWIDTH+2:0] mem_addr;
  logic                 mem_q;
  logic [7:0]           byte_out;
  logic                 byte_ready;
  logic                 sync_n;

  modport master (
    output mem_addr,
    output byte_out,
    output byte_ready,
    output sync_n,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  byte_out,
    input  byte_ready,
    input  sync_n,
    output mem_q
  );
endinterface

// File: rtl/iecdrv_gcr_reader.sv
// iecdrv_gcr_reader: bit-serial GCR track read head, SYNC detect, MSB-first byte assembly.
// Ports: clk, reset_n (async low), ce strobe, enable, track_len; bus = RAM bit port + byte outputs.
module iecdrv_gcr_reader #(
  parameter int ADDRWIDTH = 13,
  parameter int SYNC_ONES = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 enable,
  input  logic [ADDRWIDTH+2:0] track_len,
  iecdrv_gcr_reader_if.master  bus
);
  localparam int AW = ADDRWIDTH + 3;
  localparam logic [3:0] SYNC_N = 4'(SYNC_ONES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT1,
    WAIT2,
    CAPTURE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_ptr;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic [2:0]    r_bitcnt;
  logic [3:0]    r_ones;
  logic          r_ready;
  logic          r_sync_n;

  logic          w_b;
  logic          w_capture;
  logic [AW:0]   w_inc;
  logic [AW-1:0] w_ptr_nxt;
  logic [3:0]    w_ones_nxt;
  logic          w_sync_hit;
  logic [7:0]    w_shifted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (ce) w_next = WAIT1;
      WAIT1:   w_next = WAIT2;
      WAIT2:   w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!enable) w_next = IDLE;
  end

  // RAM data is valid two edges after the address was sampled, so the
  // bit is taken on the edge that leaves WAIT2 (entering CAPTURE).
  assign w_b       = bus.mem_q;
  assign w_capture = enable && (r_state == WAIT2);

  // One extra bit keeps ptr+1 from wrapping before the length compare;
  // also covers track_len 0/1 and a pointer beyond a shortened track.
  assign w_inc     = {1'b0, r_ptr} + {{AW{1'b0}}, 1'b1};
  assign w_ptr_nxt = (w_inc >= {1'b0, track_len}) ? '0 : w_inc[AW-1:0];

  always_comb begin
    w_ones_nxt = 4'd0;
    if (w_b) begin
      w_ones_nxt = (r_ones == 4'd15) ? 4'd15 : r_ones + 4'd1;
    end
  end

  assign w_sync_hit = w_b && (w_ones_nxt >= SYNC_N);
  assign w_shifted  = {r_shift[6:0], w_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_shift  <= '0;
      r_byte   <= '0;
      r_bitcnt <= '0;
      r_ones   <= '0;
      r_ready  <= 1'b0;
      r_sync_n <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      if (!enable) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_ones   <= '0;
        r_sync_n <= 1'b1;
      end else if (w_capture) begin
        r_ptr  <= w_ptr_nxt;
        r_ones <= w_ones_nxt;
        if (r_sync_n) begin
          if (w_sync_hit) begin
            r_sync_n <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
          end else begin
            r_shift  <= w_shifted;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_byte  <= w_shifted;
              r_ready <= 1'b1;
            end
          end
        end else if (!w_b) begin
          // The 0 ending a SYNC is already bit 7 of the next byte.
          r_sync_n <= 1'b1;
          r_shift  <= w_shifted;
          r_bitcnt <= 3'd1;
        end
      end
    end
  end

  assign bus.mem_addr   = r_ptr;
  assign bus.byte_out   = r_byte;
  assign bus.byte_ready = r_ready;
  assign bus.sync_n     = r_sync_n;

endmodule
